// File: rtl/atom_sequencer.sv
// atom_sequencer: walks one contiguous register-file range per instruction and
// drives the atom read port. DOT reads are gated by downstream result credits
// and completion waits for every DOT result; LOAD completes with its last read.
module atom_sequencer #(
    parameter int RF_DEPTH = 512,
    parameter int RF_ADDRW = $clog2(RF_DEPTH),
    parameter int CNTW     = 10,
    parameter int CREDITS  = 8,
    parameter int CREDW    = $clog2(CREDITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inst_valid,
    output logic                o_inst_ready,
    input  logic                i_inst_op,
    input  logic [RF_ADDRW-1:0] i_inst_base,
    input  logic [CNTW-1:0]     i_inst_count,
    output logic [RF_ADDRW-1:0] o_raddr,
    output logic                o_rvalid,
    output logic                o_rload,
    input  logic                i_atom_valid,
    input  logic                i_credit_return,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic OP_DOT  = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    localparam logic [CREDW-1:0] CRED_MAX = CREDW'(CREDITS);
    localparam logic [CREDW-1:0] CRED_ONE = CREDW'(1);
    localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);

    logic [1:0]          r_state;
    logic                r_op;
    logic [RF_ADDRW-1:0] r_base;
    logic [CNTW-1:0]     r_count;
    logic [CNTW-1:0]     r_idx;
    logic [CNTW-1:0]     r_rcvd;
    logic [CREDW-1:0]    r_credits;
    logic [RF_ADDRW-1:0] r_raddr;
    logic                r_rvalid;
    logic                r_rload;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_issue;
    logic                w_dot_issue;
    logic                w_last;
    logic                w_result_ok;
    logic                w_drained;
    logic [RF_ADDRW-1:0] w_addr;

    assign o_inst_ready = (r_state == ST_IDLE);
    assign w_accept     = i_inst_valid && o_inst_ready;
    // A credit returned this cycle only becomes visible through r_credits next cycle.
    assign w_issue      = (r_state == ST_ISSUE) && ((r_op == OP_LOAD) || (r_credits != '0));
    assign w_dot_issue  = w_issue && (r_op == OP_DOT);
    assign w_last       = ((r_idx + CNT_ONE) == r_count);
    // Truncating idx and the sum to the address width gives the modulo-depth wrap.
    assign w_addr       = r_base + RF_ADDRW'(r_idx);
    assign w_result_ok  = (r_state != ST_IDLE) && (r_op == OP_DOT) && (r_rcvd != r_count);
    assign w_drained    = (r_state == ST_DRAIN) && (r_rcvd == r_count);

    // Instruction capture and IDLE/ISSUE/DRAIN sequencing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_DOT;
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_inst_op;
                        r_base  <= i_inst_base;
                        r_count <= i_inst_count;
                        r_idx   <= '0;
                        if (i_inst_count != '0) begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_idx <= r_idx + CNT_ONE;
                        if (w_last) begin
                            r_state <= (r_op == OP_LOAD) ? ST_IDLE : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered atom read port; address holds between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_raddr  <= '0;
            r_rvalid <= 1'b0;
            r_rload  <= 1'b0;
        end else begin
            r_rvalid <= w_issue;
            r_rload  <= w_issue && (r_op == OP_LOAD);
            if (w_issue) begin
                r_raddr <= w_addr;
            end
        end
    end

    // Completion pulse: empty instruction, last LOAD read, or DOT fully drained.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_accept && (i_inst_count == '0))
                   || (w_issue && w_last && (r_op == OP_LOAD))
                   || w_drained;
        end
    end

    // Count DOT results returning from the atom.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rcvd <= '0;
        end else if (w_accept) begin
            r_rcvd <= '0;
        end else if (i_atom_valid && w_result_ok) begin
            r_rcvd <= r_rcvd + CNT_ONE;
        end
    end

    // Credit accounting and sticky protocol-error detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credits <= CRED_MAX;
            r_err     <= 1'b0;
        end else begin
            if (i_atom_valid && !w_result_ok) begin
                r_err <= 1'b1;
            end
            if (w_dot_issue && !i_credit_return) begin
                r_credits <= r_credits - CRED_ONE;
            end else if (!w_dot_issue && i_credit_return) begin
                if (r_credits == CRED_MAX) begin
                    r_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + CRED_ONE;
                end
            end
        end
    end

    assign o_raddr  = r_raddr;
    assign o_rvalid = r_rvalid;
    assign o_rload  = r_rload;
    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule

// File: tb/tb_atom_sequencer.sv
// Bench for atom_sequencer: directed boundary cases followed by randomized
// instruction streams checked through read/done scoreboards.
module tb_atom_sequencer;

    localparam int RF_DEPTH = 512;
    localparam int RF_ADDRW = 9;
    localparam int CNTW     = 10;
    localparam int CREDITS  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                i_inst_valid = 1'b0;
    logic                o_inst_ready;
    logic                i_inst_op = 1'b0;
    logic [RF_ADDRW-1:0] i_inst_base = '0;
    logic [CNTW-1:0]     i_inst_count = '0;
    logic [RF_ADDRW-1:0] o_raddr;
    logic                o_rvalid;
    logic                o_rload;
    logic                i_atom_valid = 1'b0;
    logic                i_credit_return = 1'b0;
    logic                o_busy;
    logic                o_done;
    logic                o_err;

    atom_sequencer #(
        .RF_DEPTH(RF_DEPTH),
        .RF_ADDRW(RF_ADDRW),
        .CNTW    (CNTW),
        .CREDITS (CREDITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_inst_valid   (i_inst_valid),
        .o_inst_ready   (o_inst_ready),
        .i_inst_op      (i_inst_op),
        .i_inst_base    (i_inst_base),
        .i_inst_count   (i_inst_count),
        .o_raddr        (o_raddr),
        .o_rvalid       (o_rvalid),
        .o_rload        (o_rload),
        .i_atom_valid   (i_atom_valid),
        .i_credit_return(i_credit_return),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int load; } rd_t;
    typedef struct { int op; int cnt; } dn_t;

    rd_t exp_rd[$];
    dn_t exp_dn[$];
    rd_t mon_rd;
    dn_t mon_dn;

    int n_pass = 0;
    int n_total = 0;
    bit mon_en = 1'b0;
    bit auto_resp = 1'b0;
    int pend_res = 0;
    int pend_cred = 0;
    int res_sent_cur = 0;
    int reads_cur = 0;
    int dot_reads = 0;
    int ret_driven = 0;
    int ret_prev = 0;

    function automatic void check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endfunction

    // Advance one clock; acting as atom/downstream when auto_resp is set.
    task automatic tick();
        @(posedge clk);
        #1;
        i_atom_valid    = 1'b0;
        i_credit_return = 1'b0;
        if (auto_resp) begin
            if (pend_cred > 0 && $urandom_range(0, 2) != 0) begin
                i_credit_return = 1'b1;
                pend_cred--;
                ret_driven++;
            end
            if (pend_res > 0 && $urandom_range(0, 3) != 0) begin
                i_atom_valid = 1'b1;
                pend_res--;
                pend_cred++;
                res_sent_cur++;
            end
        end
    endtask

    task automatic send(input int op, input int base, input int cnt, input bit push);
        int w;
        w = 0;
        while (!o_inst_ready && w < 500) begin
            tick();
            w++;
        end
        if (!o_inst_ready) check("ready_timeout", 0, 1);
        i_inst_valid = 1'b1;
        i_inst_op    = op[0];
        i_inst_base  = RF_ADDRW'(base);
        i_inst_count = CNTW'(cnt);
        if (push) begin
            for (int i = 0; i < cnt; i++) begin
                exp_rd.push_back('{addr: (base + i) % RF_DEPTH, load: op});
            end
            exp_dn.push_back('{op: op, cnt: cnt});
        end
        tick();
        i_inst_valid = 1'b0;
    endtask

    // Monitor: compares read-port and completion activity against the scoreboards.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_rvalid) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    check("raddr", int'(o_raddr), mon_rd.addr);
                    check("rload", int'(o_rload), mon_rd.load);
                end
                reads_cur++;
                if (!o_rload) begin
                    dot_reads++;
                    pend_res++;
                    // A DOT read needs a credit that existed before its issue edge.
                    check("credit_bound", int'(dot_reads <= CREDITS + ret_prev), 1);
                end
            end
            if (o_done) begin
                if (exp_dn.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_dn = exp_dn.pop_front();
                    check("done_reads", reads_cur, mon_dn.cnt);
                    check("done_results", res_sent_cur, (mon_dn.op == 0) ? mon_dn.cnt : 0);
                    if (mon_dn.op == 1 && mon_dn.cnt != 0) check("load_done_align", int'(o_rvalid), 1);
                end
                reads_cur = 0;
                res_sent_cur = 0;
            end
            ret_prev = ret_driven;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int op;
        int base;
        int cnt;

        // Reset state
        rst = 1'b0;
        tick(); tick(); tick();
        check("rst_ready", int'(o_inst_ready), 1);
        check("rst_rvalid", int'(o_rvalid), 0);
        check("rst_rload", int'(o_rload), 0);
        check("rst_raddr", int'(o_raddr), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_err", int'(o_err), 0);
        rst = 1'b1;
        tick();

        // count==0: done one cycle after accept, no read
        send(0, 100, 0, 1'b0);
        check("zero_done", int'(o_done), 1);
        check("zero_rvalid", int'(o_rvalid), 0);
        check("zero_busy", int'(o_busy), 0);
        tick();
        check("zero_done_clear", int'(o_done), 0);
        check("zero_rvalid2", int'(o_rvalid), 0);

        // Result in IDLE is a sticky error cleared only by reset
        i_atom_valid = 1'b1;
        tick();
        check("idle_result_err", int'(o_err), 1);
        tick();
        check("err_sticky", int'(o_err), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("err_reset", int'(o_err), 0);
        tick();

        // LOAD base=5 count=3
        send(1, 5, 3, 1'b0);
        check("ld_first_latency", int'(o_rvalid), 0);
        tick();
        check("ld0_v", int'(o_rvalid), 1); check("ld0_a", int'(o_raddr), 5);
        check("ld0_l", int'(o_rload), 1);  check("ld0_d", int'(o_done), 0);
        tick();
        check("ld1_v", int'(o_rvalid), 1); check("ld1_a", int'(o_raddr), 6);
        check("ld1_d", int'(o_done), 0);
        tick();
        check("ld2_v", int'(o_rvalid), 1); check("ld2_a", int'(o_raddr), 7);
        check("ld2_l", int'(o_rload), 1);  check("ld2_d", int'(o_done), 1);
        tick();
        check("ld_end_v", int'(o_rvalid), 0); check("ld_end_d", int'(o_done), 0);
        check("ld_end_busy", int'(o_busy), 0); check("ld_err", int'(o_err), 0);

        // DOT base=510 count=5 with 2 credits: wrap, stall, credit release, same-cycle issue+return
        send(0, 510, 5, 1'b0);
        tick();
        check("dt0_v", int'(o_rvalid), 1); check("dt0_a", int'(o_raddr), 510);
        check("dt0_l", int'(o_rload), 0);  check("dt0_busy", int'(o_busy), 1);
        tick();
        check("dt1_v", int'(o_rvalid), 1); check("dt1_a", int'(o_raddr), 511);
        tick();
        check("dt_stall0", int'(o_rvalid), 0);
        i_credit_return = 1'b1;
        tick();
        check("dt_ret_late", int'(o_rvalid), 0);
        i_credit_return = 1'b1;
        tick();
        check("dt2_v", int'(o_rvalid), 1); check("dt2_a", int'(o_raddr), 0);
        tick();
        check("dt3_v", int'(o_rvalid), 1); check("dt3_a", int'(o_raddr), 1);
        check("dt_same_cycle_err", int'(o_err), 0);
        tick();
        check("dt_stall1", int'(o_rvalid), 0);
        i_credit_return = 1'b1;
        tick();
        check("dt_stall2", int'(o_rvalid), 0);
        tick();
        check("dt4_v", int'(o_rvalid), 1); check("dt4_a", int'(o_raddr), 2);
        for (int i = 0; i < 5; i++) begin
            i_atom_valid = 1'b1;
            tick();
            check("dt_drain_nodone", int'(o_done), 0);
            check("dt_drain_busy", int'(o_busy), 1);
        end
        tick();
        check("dt_done", int'(o_done), 1);
        check("dt_done_ready", int'(o_inst_ready), 1);
        check("dt_done_busy", int'(o_busy), 0);
        tick();
        check("dt_done_clear", int'(o_done), 0);
        i_credit_return = 1'b1;
        tick();
        i_credit_return = 1'b1;
        tick();
        check("dt_err", int'(o_err), 0);

        // Reset mid-DOT after two reads
        send(0, 0, 6, 1'b0);
        tick();
        tick();
        check("mid_read1", int'(o_raddr), 1);
        rst = 1'b0;
        tick();
        check("mid_rvalid", int'(o_rvalid), 0);
        check("mid_ready", int'(o_inst_ready), 1);
        check("mid_busy", int'(o_busy), 0);
        check("mid_done", int'(o_done), 0);
        rst = 1'b1;
        tick();
        check("mid_done2", int'(o_done), 0);
        check("mid_rvalid2", int'(o_rvalid), 0);

        // Randomized instruction stream; bound on credits assumes reset restored them
        mon_en = 1'b1;
        auto_resp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            op   = int'($urandom_range(0, 1));
            base = ($urandom_range(0, 3) == 0) ? RF_DEPTH - int'($urandom_range(1, 6))
                                               : int'($urandom_range(0, RF_DEPTH - 1));
            cnt  = int'($urandom_range(0, 12));
            send(op, base, cnt, 1'b1);
        end
        w = 0;
        while ((exp_dn.size() != 0 || pend_res != 0 || pend_cred != 0) && w < 3000) begin
            tick();
            w++;
        end
        tick();
        tick();
        check("drain_done_q", exp_dn.size(), 0);
        check("drain_read_q", exp_rd.size(), 0);
        check("final_err", int'(o_err), 0);
        check("final_idle", int'(o_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
